// File: rtl/deserializer_align.sv
// Serial-to-parallel receiver that locks onto an in-band sync word every frame
// and emits the data words of each frame with a one-cycle valid strobe.
module deserializer_align #(
    parameter int unsigned          C_WIDTH        = 8,
    parameter logic [C_WIDTH-1:0]   C_SYNC_PATTERN = 8'hA5,
    parameter int unsigned          C_FRAME_WORDS  = 4,
    parameter int unsigned          C_LOCK_COUNT   = 3,
    parameter int unsigned          C_MISS_LIMIT   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               serial_i,
    input  logic               realign_i,
    output logic [C_WIDTH-1:0] word_o,
    output logic               word_valid_o,
    output logic               locked_o,
    output logic               sync_err_o
);

    localparam int unsigned BitW  = $clog2(C_WIDTH);
    localparam int unsigned WordW = $clog2(C_FRAME_WORDS);
    localparam int unsigned HitW  = $clog2(C_LOCK_COUNT + 1);
    localparam int unsigned MissW = $clog2(C_MISS_LIMIT + 1);

    localparam logic [BitW-1:0]  BitLast   = BitW'(C_WIDTH - 1);
    localparam logic [WordW-1:0] WordLast  = WordW'(C_FRAME_WORDS - 1);
    localparam logic [HitW-1:0]  HitFinal  = HitW'(C_LOCK_COUNT - 1);
    localparam logic [MissW-1:0] MissFinal = MissW'(C_MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [C_WIDTH-1:0] sr_q, sr_next;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WordW-1:0]   word_cnt_q, word_cnt_d;
    logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [MissW-1:0]   miss_cnt_q, miss_cnt_d;
    logic [C_WIDTH-1:0] word_q, word_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic sync_match;
    logic word_done;
    logic sync_slot;

    // The candidate word already includes the bit arriving on this edge.
    assign sr_next    = {serial_i, sr_q[C_WIDTH-1:1]};
    assign sync_match = (sr_next == C_SYNC_PATTERN);
    assign word_done  = (bit_cnt_q == BitLast);
    assign sync_slot  = (word_cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = word_done ? '0 : bit_cnt_q + 1'b1;
        word_cnt_d = word_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (word_done) begin
            word_cnt_d = (word_cnt_q == WordLast) ? '0 : word_cnt_q + 1'b1;
        end

        if (realign_i) begin
            state_d    = StHunt;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            unique case (state_q)
                StHunt: begin
                    // Bit phase is unknown here, so every cycle is a candidate boundary.
                    if (sync_match) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = WordW'(1);
                        hit_cnt_d  = HitW'(1);
                        miss_cnt_d = '0;
                        state_d    = (C_LOCK_COUNT == 1) ? StLocked : StVerify;
                    end
                end
                StVerify: begin
                    if (word_done && sync_slot) begin
                        if (sync_match) begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                            if (hit_cnt_q == HitFinal) begin
                                state_d = StLocked;
                            end
                        end else begin
                            state_d    = StHunt;
                            hit_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (word_done) begin
                        if (!sync_slot) begin
                            word_d  = sr_next;
                            valid_d = 1'b1;
                        end else if (sync_match) begin
                            miss_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (miss_cnt_q == MissFinal) begin
                                state_d    = StHunt;
                                miss_cnt_d = '0;
                                hit_cnt_d  = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d    = StHunt;
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StHunt;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_next;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign sync_err_o   = err_q;
    assign locked_o     = (state_q == StLocked);

endmodule

// File: tb/tb_deserializer_align.sv
// Bench for deserializer_align: directed scenarios plus random frames, every cycle
// compared against a bit-history / frame-position model of the receiver.
module tb_deserializer_align;

    localparam int unsigned W     = 8;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam int unsigned FRAME = 4;
    localparam int unsigned LOCK  = 3;
    localparam int unsigned MISS  = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic       serial = 1'b0;
    logic       realign = 1'b0;
    logic [7:0] word_o;
    logic       word_valid_o;
    logic       locked_o;
    logic       sync_err_o;

    always #5 clk = ~clk;

    deserializer_align #(
        .C_WIDTH        (W),
        .C_SYNC_PATTERN (SYNC),
        .C_FRAME_WORDS  (FRAME),
        .C_LOCK_COUNT   (LOCK),
        .C_MISS_LIMIT   (MISS)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .serial_i     (serial),
        .realign_i    (realign),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .locked_o     (locked_o),
        .sync_err_o   (sync_err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 hunting, 1 confirming, 2 locked. Word boundaries are derived
    // from the edge index of the last hunt match rather than from counters.
    bit         hist[$];
    int         m_mode, m_hits, m_misses, m_t, m_anchor;
    logic [7:0] m_word;
    bit         m_valid, m_err;

    int         edge_n;
    int         lock_rise;
    bit         prev_locked;
    int         n_err_pulses;
    logic [7:0] vwords[$];
    int         vedges[$];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(W); i++) hist.push_back(1'b0);
        m_mode = 0; m_hits = 0; m_misses = 0; m_t = 0; m_anchor = 0;
        m_word = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit ra);
        logic [7:0] cand;
        int rel, slot;
        hist.push_back(b);
        void'(hist.pop_front());
        for (int i = 0; i < int'(W); i++) cand[i] = hist[i];
        m_t++;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (ra) begin
            m_mode = 0; m_hits = 0; m_misses = 0;
        end else if (m_mode == 0) begin
            if (cand == SYNC) begin
                m_anchor = m_t; m_hits = 1; m_misses = 0;
                m_mode = (LOCK == 1) ? 2 : 1;
            end
        end else begin
            rel = m_t - m_anchor;
            if (rel % int'(W) == 0) begin
                slot = (rel / int'(W)) % int'(FRAME);
                if (m_mode == 1) begin
                    if (slot == 0) begin
                        if (cand == SYNC) begin
                            m_hits++;
                            if (m_hits == int'(LOCK)) m_mode = 2;
                        end else begin
                            m_mode = 0; m_hits = 0; m_misses = 0;
                        end
                    end
                end else if (slot != 0) begin
                    m_word = cand; m_valid = 1'b1;
                end else if (cand == SYNC) begin
                    m_misses = 0;
                end else begin
                    m_err = 1'b1;
                    m_misses++;
                    if (m_misses == int'(MISS)) begin
                        m_mode = 0; m_misses = 0; m_hits = 0;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic check_outputs();
        cmp("word_o", {24'd0, word_o}, {24'd0, m_word});
        cmp("word_valid_o", {31'd0, word_valid_o}, {31'd0, m_valid});
        cmp("locked_o", {31'd0, locked_o}, {31'd0, (m_mode == 2)});
        cmp("sync_err_o", {31'd0, sync_err_o}, {31'd0, m_err});
    endtask

    task automatic send_bit(input bit b, input bit ra);
        serial  = b;
        realign = ra;
        @(posedge clk);
        model_step(b, ra);
        #1;
        check_outputs();
        if (locked_o && !prev_locked) lock_rise = edge_n;
        prev_locked = locked_o;
        if (word_valid_o) begin
            vwords.push_back(word_o);
            vedges.push_back(edge_n);
        end
        if (sync_err_o) n_err_pulses++;
        edge_n++;
        realign = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit ra_last);
        for (int i = 0; i < int'(W); i++) send_bit(w[i], ra_last && (i == int'(W) - 1));
    endtask

    task automatic send_frame(input logic [7:0] s);
        send_word(s, 1'b0);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
    endtask

    task automatic clear_log();
        lock_rise = -1;
        n_err_pulses = 0;
        vwords.delete();
        vedges.delete();
    endtask

    // Asserts reset between clock edges and checks outputs clear immediately.
    task automatic apply_reset();
        #3;
        rst_ni = 1'b0;
        model_reset();
        #1;
        cmp("reset word_o", {24'd0, word_o}, 32'd0);
        cmp("reset word_valid_o", {31'd0, word_valid_o}, 32'd0);
        cmp("reset locked_o", {31'd0, locked_o}, 32'd0);
        cmp("reset sync_err_o", {31'd0, sync_err_o}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst_ni = 1'b1;
        edge_n = 0;
        prev_locked = 1'b0;
        clear_log();
    endtask

    task automatic check_frame_words(input string tag, input int first_edge);
        logic [7:0] ew[3];
        ew[0] = 8'h11; ew[1] = 8'h22; ew[2] = 8'h33;
        cmp({tag, " valid count"}, vwords.size(), 32'd3);
        for (int i = 0; i < 3 && i < vwords.size(); i++) begin
            cmp({tag, " word"}, {24'd0, vwords[i]}, {24'd0, ew[i]});
            cmp({tag, " valid edge"}, vedges[i], first_edge + 8 * i);
        end
    endtask

    initial begin
        model_reset();
        edge_n = 0;
        apply_reset();

        // Clean lock from cycle 0.
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        cmp("clean lock edge", lock_rise, 32'd71);
        check_frame_words("clean", 79);
        send_frame(SYNC);

        // Same stream shifted by three random bits.
        apply_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        cmp("offset lock edge", lock_rise, 32'd74);
        check_frame_words("offset", 82);

        // A5 in a data slot while hunting, rejected at its implied sync slot.
        apply_reset();
        send_word(8'h00, 1'b0);
        send_word(8'h00, 1'b0);
        send_word(SYNC, 1'b0);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h5A, 1'b0);
        cmp("false match locked", {31'd0, locked_o}, 32'd0);
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        cmp("false match lock edge", lock_rise, 32'd127);
        check_frame_words("false match", 135);

        // Single miss held, two consecutive misses drop lock.
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        send_frame(8'hA4);
        cmp("single miss err pulses", n_err_pulses, 32'd1);
        cmp("single miss locked", {31'd0, locked_o}, 32'd1);
        send_frame(SYNC);
        send_frame(8'hA4);
        send_word(8'hA4, 1'b0);
        cmp("double miss err pulses", n_err_pulses, 32'd3);
        cmp("double miss locked", {31'd0, locked_o}, 32'd0);
        clear_log();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        for (int f = 0; f < 6; f++) send_frame(SYNC);
        cmp("relock after drop", {31'd0, locked_o}, 32'd1);
        cmp("no valid before relock", (vedges.size() > 0 && vedges[0] < lock_rise), 32'd0);

        // realign on the edge that completes a data word.
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        send_word(SYNC, 1'b0);
        send_word(8'h11, 1'b1);
        cmp("realign valid", {31'd0, word_valid_o}, 32'd0);
        cmp("realign locked", {31'd0, locked_o}, 32'd0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        cmp("realign relock", {31'd0, locked_o}, 32'd1);

        // Async reset mid-word while locked, then a clean relock.
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        send_word(SYNC, 1'b0);
        send_word(8'h11, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h22 >> i), 1'b0);
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(SYNC);
        cmp("post reset lock edge", lock_rise, 32'd71);
        check_frame_words("post reset", 79);

        // Random noise followed by random frames with occasional bad syncs and realigns.
        apply_reset();
        for (int i = 0; i < 120; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int f = 0; f < 60; f++) begin
            logic [7:0] w;
            for (int s = 0; s < int'(FRAME); s++) begin
                if (s == 0) begin
                    w = SYNC;
                    if ($urandom_range(0, 5) == 0) w = SYNC ^ (8'h01 << $urandom_range(0, 7));
                end else begin
                    w = 8'($urandom);
                end
                for (int i = 0; i < int'(W); i++) send_bit(w[i], $urandom_range(0, 399) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
